// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// The defaults describe the usual 4-bit "1011" detector with an 8-bit match counter.
package seq_pattern_detector_pkg;

   localparam int         DEF_PAT_W   = 4;
   localparam logic [3:0] DEF_PATTERN = 4'b1011;
   localparam int         DEF_CNT_W   = 8;

   // Saturating increment: stays at max instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
      return (cnt >= max) ? max : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides the increment.
module sat_counter
   import seq_pattern_detector_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] value_o
);

   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] value_q;

   // Clear wins over increment so software can zero the count on any cycle,
   // and the count parks at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else if (clr_i) begin
         value_q <= '0;
      end else if (inc_i) begin
         value_q <= CNT_W'(sat_inc(32'(value_q), 32'(MAX)));
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts in qualified bits, compares the newest PAT_W
// bits against PATTERN and pulses match for one cycle per completed pattern.
module seq_pattern_detector
   import seq_pattern_detector_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   input  logic             clr_cnt,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [PAT_W-1:0] shreg,
   output logic             primed
);

   localparam int               FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  shiftReg_q;
   logic [PAT_W-1:0]  shiftReg_d;
   logic [PAT_W-1:0]  shiftIn;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_d;
   logic [FILL_W-1:0] fillInc;
   logic              match_q;
   logic              primed_q;
   logic              hit;

   // Work out what the history and fill counter become if this edge samples a bit.
   // A hit needs both a full history and an exact compare; without OVERLAP a hit
   // wipes the history so the next match has to be built from fresh bits.
   always_comb begin
      shiftIn    = {shiftReg_q[PAT_W-2:0], din};
      fillInc    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      hit        = din_vld && (fillInc == FILL_FULL) && (shiftIn == PATTERN);
      shiftReg_d = shiftReg_q;
      fill_d     = fill_q;
      if (din_vld) begin
         if (hit && !OVERLAP) begin
            shiftReg_d = '0;
            fill_d     = '0;
         end else begin
            shiftReg_d = shiftIn;
            fill_d     = fillInc;
         end
      end
   end

   // History, fill and the registered flags all move together; a reset at any
   // point throws away everything seen so far.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shiftReg_q <= '0;
         fill_q     <= '0;
         match_q    <= 1'b0;
         primed_q   <= 1'b0;
      end else begin
         shiftReg_q <= shiftReg_d;
         fill_q     <= fill_d;
         match_q    <= hit;
         primed_q   <= (fill_d == FILL_FULL);
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_matchCnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_cnt),
      .inc_i   (hit),
      .value_o (match_cnt)
   );

   assign match  = match_q;
   assign shreg  = shiftReg_q;
   assign primed = primed_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three instances (default, non-overlapping,
// 2-bit counter) share one stimulus stream and are checked against a model that
// keeps the raw list of sampled bits and reasons about the last PAT_W of them.
module tb_seq_pattern_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_vld = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       matchA, matchB, matchC;
   logic [7:0] cntA, cntB;
   logic [1:0] cntC;
   logic [3:0] shregA, shregB, shregC;
   logic       primedA, primedB, primedC;

   int checks = 0;
   int errors = 0;

   always #20 clk = ~clk;

   seq_pattern_detector dutA (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
      .match(matchA), .match_cnt(cntA), .shreg(shregA), .primed(primedA)
   );

   seq_pattern_detector #(.OVERLAP(1'b0)) dutB (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
      .match(matchB), .match_cnt(cntB), .shreg(shregB), .primed(primedB)
   );

   seq_pattern_detector #(.CNT_W(2)) dutC (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
      .match(matchC), .match_cnt(cntC), .shreg(shregC), .primed(primedC)
   );

   // Reference model: every sampled bit goes into one stream; each instance
   // remembers where its current history starts (moved by reset or by a
   // non-overlapping match).
   logic [3:0] benchPattern = 4'b1011;
   bit         stream[$];
   int         startIdx[3];
   int         expCnt[3];
   bit         expMatch[3];
   int         cntMax[3]      = '{255, 255, 3};
   bit         overlapMode[3] = '{1'b1, 1'b0, 1'b1};

   function automatic int histLen(int k);
      return stream.size() - startIdx[k];
   endfunction

   function automatic bit tailIsPattern();
      for (int i = 0; i < 4; i++)
         if (stream[stream.size() - 1 - i] != benchPattern[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int expShreg(int k);
      int n = histLen(k);
      int v = 0;
      if (n > 4) n = 4;
      for (int i = 0; i < n; i++)
         if (stream[stream.size() - 1 - i]) v = v | (1 << i);
      return v;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         startIdx[k] = stream.size();
         expCnt[k]   = 0;
         expMatch[k] = 1'b0;
      end
   endtask

   task automatic modelStep(input bit d, input bit v, input bit c, input bit r);
      bit hitK;
      if (r) begin
         modelReset();
         return;
      end
      if (v) stream.push_back(d);
      for (int k = 0; k < 3; k++) begin
         hitK        = v && (histLen(k) >= 4) && tailIsPattern();
         expMatch[k] = hitK;
         if (c) expCnt[k] = 0;
         else if (hitK) expCnt[k] = (expCnt[k] + 1 > cntMax[k]) ? cntMax[k] : expCnt[k] + 1;
         if (hitK && !overlapMode[k]) startIdx[k] = stream.size();
      end
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareAll();
      int am, ac, as, ap;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin am = int'(matchA); ac = int'(cntA); as = int'(shregA); ap = int'(primedA); end
            1:       begin am = int'(matchB); ac = int'(cntB); as = int'(shregB); ap = int'(primedB); end
            default: begin am = int'(matchC); ac = int'(cntC); as = int'(shregC); ap = int'(primedC); end
         endcase
         checkOutput($sformatf("dut%0d.match", k), am, int'(expMatch[k]));
         checkOutput($sformatf("dut%0d.match_cnt", k), ac, expCnt[k]);
         checkOutput($sformatf("dut%0d.shreg", k), as, expShreg(k));
         checkOutput($sformatf("dut%0d.primed", k), ap, int'(histLen(k) >= 4));
      end
   endtask

   // Called 1 ns after a rising edge: drive, take the next edge, compare 1 ns later.
   task automatic applyStimulus(input bit d, input bit v, input bit c);
      din     = d;
      din_vld = v;
      clr_cnt = c;
      if (din_vld && $isunknown(din)) begin
         errors++;
         $display("[TB] FAIL din_known: din is X/Z while din_vld=1 at %0t", $time);
      end
      @(posedge clk);
      modelStep(d, v, c, rst);
      #1;
      compareAll();
   endtask

   task automatic doReset();
      rst = 1'b1;
      #2;
      modelReset();
      compareAll();
      rst = 1'b0;
   endtask

   typedef struct {
      bit d;
      bit v;
      bit c;
      bit expM;
      int expC;
   } vec_t;

   vec_t basicVecs[5];
   int   pulsesA, pulsesB;
   bit   seqBits[7] = '{1, 0, 1, 1, 0, 1, 1};

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      basicVecs[0] = '{d: 1, v: 1, c: 0, expM: 0, expC: 0};
      basicVecs[1] = '{d: 0, v: 1, c: 0, expM: 0, expC: 0};
      basicVecs[2] = '{d: 1, v: 1, c: 0, expM: 0, expC: 0};
      basicVecs[3] = '{d: 1, v: 1, c: 0, expM: 1, expC: 1};
      basicVecs[4] = '{d: 0, v: 0, c: 0, expM: 0, expC: 1};

      // T1: power-on reset, then reset held while a full pattern is driven
      #10 rst = 1'b1;
      #1;
      modelReset();
      compareAll();
      #19 rst = 1'b0;
      @(posedge clk);
      #1;
      compareAll();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(benchPattern[3 - i], 1'b1, 1'b0);
         checkOutput("t1_match_in_reset", int'(matchA), 0);
      end
      checkOutput("t1_cnt_in_reset", int'(cntA), 0);
      rst = 1'b0;

      // T2: table-driven basic detection
      for (int i = 0; i < 5; i++) begin
         applyStimulus(basicVecs[i].d, basicVecs[i].v, basicVecs[i].c);
         checkOutput($sformatf("t2_match[%0d]", i), int'(matchA), int'(basicVecs[i].expM));
         checkOutput($sformatf("t2_cnt[%0d]", i), int'(cntA), basicVecs[i].expC);
      end
      checkOutput("t2_primed", int'(primedA), 1);

      // T3: overlapping vs non-overlapping on 1011011
      doReset();
      pulsesA = 0;
      pulsesB = 0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(seqBits[i], 1'b1, 1'b0);
         pulsesA += int'(matchA);
         pulsesB += int'(matchB);
      end
      checkOutput("t3_pulses_overlap", pulsesA, 2);
      checkOutput("t3_pulses_nooverlap", pulsesB, 1);
      checkOutput("t3_cnt_overlap", int'(cntA), 2);
      checkOutput("t3_cnt_nooverlap", int'(cntB), 1);

      // T4: invalid cycles in the middle of a pattern hold the history
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         checkOutput("t4_shreg_gap", int'(shregA), 4'b0010);
         checkOutput("t4_match_gap", int'(matchA), 0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t4_match_early", int'(matchA), 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t4_match_final", int'(matchA), 1);
      checkOutput("t4_cnt_final", int'(cntA), 1);

      // T5: five overlapping matches saturate the 2-bit counter, then clear on a hit
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(benchPattern[3 - i], 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         applyStimulus(1'b1, 1'b1, 1'b0);
         applyStimulus(1'b1, 1'b1, 1'b0);
      end
      checkOutput("t5_cnt_saturated", int'(cntC), 3);
      checkOutput("t5_cnt_wide", int'(cntA), 5);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("t5_match_with_clr", int'(matchA), 1);
      checkOutput("t5_cnt_clr_wins", int'(cntA), 0);
      checkOutput("t5_cnt_clr_sat", int'(cntC), 0);

      // T6: asynchronous reset mid-stream discards the partial pattern
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      #2;
      modelReset();
      compareAll();
      checkOutput("t6_async_shreg", int'(shregA), 0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t6_no_stale_match", int'(matchA), 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t6_not_primed_yet", int'(primedA), 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t6_match_after_refill", int'(matchA), 1);

      // Randomized run against the model, including occasional resets and clears
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 39) == 0));
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
